mips_multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and mux selects, and produces the 2-bit ALUOp consumed by the ALU decoder.
- Supports a memory-ready handshake so fetch and data accesses can stall on slow memory.

---
 rtl/mips_multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback with memory-ready stalls.
module mips_multicycle_controller #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic       InstrDone,
  output logic [3:0] State
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_rdy;
  logic   w_pcwrite;
  logic   w_branch;

  assign w_rdy = USE_MEM_READY ? MemReady : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    IllegalOp = 1'b0;
    InstrDone = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        IRWrite   = w_rdy;
        w_pcwrite = w_rdy;
        w_next    = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RT:        w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            InstrDone = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = w_rdy;
        w_next    = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSrc     = 2'b01;
        w_branch  = 1'b1;
        InstrDone = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
        InstrDone = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    PCEn  = w_pcwrite | (w_branch & Zero);
    State = r_state;
    // Reset masks everything so an abandoned instruction issues no writes
    if (reset) begin
      IorD      = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      PCSrc     = 2'b00;
      PCEn      = 1'b0;
      IllegalOp = 1'b0;
      InstrDone = 1'b0;
      State     = 4'd0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed scoreboard bench for the multi-cycle MIPS controller.
// Expected per-cycle output vectors are queued, then checked mid-cycle.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCEn, IllegalOp, InstrDone;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  mips_multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .IllegalOp(IllegalOp), .InstrDone(InstrDone), .State(State)
  );

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  function automatic logic [19:0] pk(
    input logic [3:0] st, input logic iord, input logic mw,
    input logic irw, input logic rd, input logic m2r,
    input logic rw, input logic sa, input logic [1:0] sb,
    input logic [1:0] aop, input logic [1:0] pcs,
    input logic pcen, input logic ill, input logic done);
    return {st, iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs,
            pcen, ill, done};
  endfunction

  logic [19:0] E_RST, E_F, E_FST, E_D, E_DILL, E_MADR, E_MRD;
  logic [19:0] E_MWB, E_MWRS, E_MWR, E_EX, E_AWB, E_BRT, E_BRN;
  logic [19:0] E_AIEX, E_AIWB, E_J;

  task automatic cyc(input logic rst, input logic [5:0] op,
                     input logic mr, input logic z,
                     input logic [19:0] exp, input string tag);
    logic [19:0] obs, e;
    @(negedge clk);
    reset = rst; Op = op; MemReady = mr; Zero = z;
    sb_q.push_back(exp);
    #2;
    obs = {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn,
           IllegalOp, InstrDone};
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    E_RST  = '0;
    E_F    = pk(0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
    E_FST  = pk(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    E_D    = pk(1,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    E_DILL = pk(1,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1,1);
    E_MADR = pk(2,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    E_MRD  = pk(3,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    E_MWB  = pk(4,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,1);
    E_MWRS = pk(5,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    E_MWR  = pk(5,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1);
    E_EX   = pk(6,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
    E_AWB  = pk(7,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,1);
    E_BRT  = pk(8,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,1);
    E_BRN  = pk(8,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,1);
    E_AIEX = pk(9,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    E_AIWB = pk(10,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,1);
    E_J    = pk(11,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,1);

    reset = 1'b1; Op = LW; MemReady = 1'b1; Zero = 1'b0;
    cyc(1, LW, 1, 0, E_RST, "reset0");
    cyc(1, LW, 1, 0, E_RST, "reset1");
    // lw
    cyc(0, LW, 1, 0, E_F,    "lw_fetch");
    cyc(0, LW, 1, 0, E_D,    "lw_decode");
    cyc(0, LW, 1, 0, E_MADR, "lw_memadr");
    cyc(0, LW, 1, 0, E_MRD,  "lw_memrd");
    cyc(0, LW, 1, 0, E_MWB,  "lw_memwb");
    // sw with three stall cycles in MEMWR
    cyc(0, SW, 1, 0, E_F,    "sw_fetch");
    cyc(0, SW, 1, 0, E_D,    "sw_decode");
    cyc(0, SW, 1, 0, E_MADR, "sw_memadr");
    cyc(0, SW, 0, 0, E_MWRS, "sw_stall0");
    cyc(0, SW, 0, 0, E_MWRS, "sw_stall1");
    cyc(0, SW, 0, 0, E_MWRS, "sw_stall2");
    cyc(0, SW, 1, 0, E_MWR,  "sw_done");
    // R-type with a fetch stall; Op changes after decode are ignored
    cyc(0, RT, 0, 0, E_FST,  "rt_fetch_stall");
    cyc(0, RT, 1, 0, E_F,    "rt_fetch");
    cyc(0, RT, 1, 0, E_D,    "rt_decode");
    cyc(0, SW, 1, 0, E_EX,   "rt_execute");
    cyc(0, LW, 1, 0, E_AWB,  "rt_aluwb");
    // beq taken / not taken
    cyc(0, BEQ, 1, 1, E_F,   "beqt_fetch");
    cyc(0, BEQ, 1, 1, E_D,   "beqt_decode");
    cyc(0, BEQ, 1, 1, E_BRT, "beqt_branch");
    cyc(0, BEQ, 1, 0, E_F,   "beqn_fetch");
    cyc(0, BEQ, 1, 0, E_D,   "beqn_decode");
    cyc(0, BEQ, 1, 0, E_BRN, "beqn_branch");
    // addi
    cyc(0, ADDI, 1, 0, E_F,    "addi_fetch");
    cyc(0, ADDI, 1, 0, E_D,    "addi_decode");
    cyc(0, ADDI, 1, 0, E_AIEX, "addi_ex");
    cyc(0, ADDI, 1, 0, E_AIWB, "addi_wb");
    // jump
    cyc(0, JMP, 1, 0, E_F, "j_fetch");
    cyc(0, JMP, 1, 0, E_D, "j_decode");
    cyc(0, JMP, 1, 0, E_J, "j_jump");
    // illegal opcode
    cyc(0, BAD, 1, 0, E_F,    "ill_fetch");
    cyc(0, BAD, 1, 0, E_DILL, "ill_decode");
    // lw with a MEMRD stall
    cyc(0, LW, 1, 0, E_F,    "lws_fetch");
    cyc(0, LW, 1, 0, E_D,    "lws_decode");
    cyc(0, LW, 1, 0, E_MADR, "lws_memadr");
    cyc(0, LW, 0, 0, E_MRD,  "lws_memrd_stall");
    cyc(0, LW, 1, 0, E_MRD,  "lws_memrd");
    cyc(0, LW, 1, 0, E_MWB,  "lws_memwb");
    // reset while stalled in MEMWR
    cyc(0, SW, 1, 0, E_F,    "rsw_fetch");
    cyc(0, SW, 1, 0, E_D,    "rsw_decode");
    cyc(0, SW, 1, 0, E_MADR, "rsw_memadr");
    cyc(0, SW, 0, 0, E_MWRS, "rsw_stall");
    cyc(1, SW, 0, 0, E_RST,  "rsw_reset");
    cyc(0, SW, 0, 0, E_FST,  "rsw_after_stall");
    cyc(0, SW, 1, 0, E_F,    "rsw_after_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
